// File: rtl/rr_bus_arbiter_pkg.sv
// Purpose: shared constants and state encoding for the internal-bus round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_bus_arbiter_pkg;

    // Bus drivers: register-file outputs, PC, MDR, ALU result and friends.
    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/decoder_4_16.sv
// Purpose: expand a 4-bit driver index into a 16-bit one-hot vector.
// Latency: combinational.
// Backpressure: none.
module decoder_4_16 (
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);

    // Exactly one output bit set for every index value.
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Purpose: round-robin owner selection for the shared internal bus, with hold limit.
// Latency: one cycle from request sample to grant; one turnaround cycle between owners.
// Backpressure: owner keeps the bus until it releases, drops its request or hits MAX_HOLD.
module rr_bus_arbiter
    import rr_bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,  // 0 disables the hold limit
    parameter int HOLD_W   = 4   // needs 2**HOLD_W > MAX_HOLD
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [15:0]      req,
    // "release" is a reserved word in SystemVerilog, hence the prefix.
    input  logic             bus_release,
    output logic [15:0]      grant,
    output logic [3:0]       grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [HOLD_W-1:0]  hold;

    logic [N_REQ-1:0]   masked;
    logic [IDX_W-1:0]   winner;
    logic               limit_hit;
    logic               owner_drop;
    logic               own_end;
    logic [N_REQ-1:0]   idx_onehot;

    // Lowest set bit of a request vector; callers guarantee a non-zero input
    // whenever the result is used.
    function automatic logic [IDX_W-1:0] first_set(input logic [N_REQ-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Rotating priority: search from ptr upward first, then wrap to the bottom.
    always_comb begin
        masked = req & ({N_REQ{1'b1}} << ptr);
        if (|masked) winner = first_set(masked);
        else         winner = first_set(req);
    end

    // Ownership-end causes; the timeout only counts when it is the sole cause.
    always_comb begin
        limit_hit  = (MAX_HOLD != 0) && (hold == HOLD_LIM);
        owner_drop = !req[grant_idx];
        own_end    = bus_release || owner_drop || limit_hit;
    end

    // Arbitration FSM with registered outputs; pointer moves past each winner.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            ptr         <= '0;
            hold        <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (|req) begin
                        state       <= OWN;
                        grant_idx   <= winner;
                        grant_valid <= 1'b1;
                        ptr         <= winner + IDX_W'(1);
                        hold        <= HOLD_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                OWN: begin
                    if (own_end) begin
                        state       <= GAP;
                        grant_idx   <= '0;
                        grant_valid <= 1'b0;
                        hold        <= '0;
                        timeout     <= limit_hit && !bus_release && !owner_drop;
                    end else if (hold != '1) begin
                        hold <= hold + HOLD_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_idx   <= '0;
                    grant_valid <= 1'b0;
                    hold        <= '0;
                end
            endcase
        end
    end

    decoder_4_16 u_dec (
        .sel    (grant_idx),
        .onehot (idx_onehot)
    );

    // Bus enables come only from registered state, gated by ownership.
    always_comb begin
        grant = idx_onehot & {N_REQ{grant_valid}};
    end

endmodule
